// File: rtl/sram_arbiter_if.sv
// Requester-side and SRAM-side signals of the lane arbiter.
// The slave modport is the arbiter's view; the master modport is the lanes plus the SRAM.
interface sram_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    we;
  logic [NUM_REQ*14-1:0] addr;
  logic [NUM_REQ*32-1:0] wd;
  logic [NUM_REQ-1:0]    ack;
  logic [31:0]           rdata;
  logic                  busy;
  logic [13:0]           mem_addr;
  logic                  mem_we;
  logic [31:0]           mem_wd;
  logic [31:0]           mem_rd;

  modport slave (
    input  req, we, addr, wd, mem_rd,
    output ack, rdata, busy, mem_addr, mem_we, mem_wd
  );

  modport master (
    output req, we, addr, wd, mem_rd,
    input  ack, rdata, busy, mem_addr, mem_we, mem_wd
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ lanes.
// Each grant takes one access cycle and one ack cycle; grants can chain back to back.
module sram_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTRW    = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          reset,
  sram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_reg;
  logic [PTRW-1:0] ptr_reg;
  logic [PTRW-1:0] owner_reg;
  logic [13:0]     lat_addr_reg;
  logic            lat_we_reg;
  logic [31:0]     lat_wd_reg;
  logic [31:0]     rdata_reg;

  logic [13:0]        addr_arr [NUM_REQ];
  logic [31:0]        wd_arr   [NUM_REQ];
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] ack;
  logic               win_valid;
  logic [PTRW-1:0]    win_idx;
  logic [PTRW-1:0]    win_next;
  logic [PTRW:0]      scan_sum;
  logic [PTRW-1:0]    scan_idx;

  // The lane being acked may still hold req during RESP, so it is masked out there.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign addr_arr[gi] = bus.addr[14*gi +: 14];
      assign wd_arr[gi]   = bus.wd[32*gi +: 32];
      assign cand[gi]     = bus.req[gi] && !(state_reg == RESP && owner_reg == PTRW'(gi));
      assign ack[gi]      = (state_reg == RESP) && (owner_reg == PTRW'(gi));
    end
  endgenerate

  // Scan from the highest offset down so the lowest offset from ptr is the last writer.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, ptr_reg} + (PTRW+1)'(k);
      if (scan_sum >= (PTRW+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (PTRW+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[PTRW-1:0];
      if (cand[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
    win_next = (win_idx == PTRW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      lat_addr_reg <= '0;
      lat_we_reg   <= 1'b0;
      lat_wd_reg   <= '0;
      rdata_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE, RESP: begin
          if (win_valid) begin
            owner_reg    <= win_idx;
            lat_addr_reg <= addr_arr[win_idx];
            lat_we_reg   <= bus.we[win_idx];
            lat_wd_reg   <= wd_arr[win_idx];
            ptr_reg      <= win_next;
            state_reg    <= ACCESS;
          end else begin
            state_reg <= IDLE;
          end
        end
        ACCESS: begin
          if (!lat_we_reg) begin
            rdata_reg <= bus.mem_rd;
          end
          state_reg <= RESP;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Gating with reset keeps a write from landing on the same edge that aborts it.
  assign bus.mem_we   = (state_reg == ACCESS) && lat_we_reg && !reset;
  assign bus.mem_addr = lat_addr_reg;
  assign bus.mem_wd   = lat_wd_reg;
  assign bus.rdata    = rdata_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.ack      = ack;
endmodule
